rf_wport_arb: RTL and testbench

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rf_arb_pick.sv | 34 +++
 rtl/rf_wport_arb.sv | 101 ++++++++++
 tb/tb_rf_wport_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the default widths, the hard-wired zero register number and the conflict-counter ceiling.
package rf_arb_pkg;

    localparam int         DATA_W_DEF   = 32;
    localparam int         ADDR_W_DEF   = 5;
    localparam int         ZERO_REG     = 0;
    localparam logic [7:0] CONFLICT_MAX = 8'd255;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    function automatic logic [1:0] onehot_of(req_id_e id);
        return (id == REQ_LOAD) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rf_arb_pick.sv
// Two-way grant selection: valids, hold and last winner in, one-hot grant out.
// RF_WPORT_ARB_FIXED_PRIO_EN makes the load requester win every tie and drops the last_grant input.
module rf_arb_pick
    import rf_arb_pkg::*;
(
    input  logic       hold,
    input  logic [1:0] valid,
`ifndef RF_WPORT_ARB_FIXED_PRIO_EN
    input  req_id_e    last_grant,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            case (valid)
                2'b01:   grant = onehot_of(REQ_ALU);
                2'b10:   grant = onehot_of(REQ_LOAD);
                2'b11: begin
`ifdef RF_WPORT_ARB_FIXED_PRIO_EN
                    grant = onehot_of(REQ_LOAD);
`else
                    // round-robin: whoever did not win last time goes now
                    grant = (last_grant == REQ_ALU) ? onehot_of(REQ_LOAD)
                                                    : onehot_of(REQ_ALU);
`endif
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Arbitrates the ALU and load writeback requesters onto one register-file write port.
// Define RF_WPORT_ARB_FIXED_PRIO_EN for fixed load-wins priority instead of round-robin.
module rf_wport_arb
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        conflict_cnt
);

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic [1:0]        xfer;
    logic              any_xfer;
    logic              refused;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign valid = {req1_valid, req0_valid};

`ifdef RF_WPORT_ARB_FIXED_PRIO_EN
    rf_arb_pick u_pick (
        .hold  (hold),
        .valid (valid),
        .grant (grant)
    );
`else
    // last_grant | meaning
    // REQ_ALU    | requester 0 won the most recent transfer
    // REQ_LOAD   | requester 1 won it (also the reset value, so 0 wins the first tie)
    req_id_e last_grant;

    rf_arb_pick u_pick (
        .hold       (hold),
        .valid      (valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            last_grant <= REQ_LOAD;
        end else if (xfer[1]) begin
            last_grant <= REQ_LOAD;
        end else if (xfer[0]) begin
            last_grant <= REQ_ALU;
        end
    end
`endif

    // gating with Clrn keeps both readies low for the whole reset window
    assign ready      = grant & {2{Clrn}};
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    assign xfer     = valid & ready;
    assign any_xfer = |xfer;
    assign refused  = |(valid & ~ready);
    assign sel_addr = xfer[1] ? req1_addr : req0_addr;
    assign sel_data = xfer[1] ? req1_data : req0_data;

    // register 0 is hard-wired: the transfer completes but never strobes the file
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= any_xfer && (sel_addr != ADDR_W'(ZERO_REG));
            if (any_xfer) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            conflict_cnt <= 8'd0;
        end else if (refused && (conflict_cnt != CONFLICT_MAX)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: directed scenarios plus a randomized phase
// against a transaction-level model of the arbitration rules.
module tb_rf_wport_arb;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef RF_WPORT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          Clk;
    logic          Clrn;
    logic          hold;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    conflict_cnt;

    rf_wport_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk          (Clk),
        .Clrn         (Clrn),
        .hold         (hold),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .conflict_cnt (conflict_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_last  = 1;
    int          m_cnt   = 0;
    bit          m_wen   = 1'b0;
    logic [31:0] m_waddr = '0;
    logic [31:0] m_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -1 none, otherwise the requester the rules say should be accepted now
    function automatic int winner();
        if (!Clrn || hold) return -1;
        if (req0_valid && req1_valid) return FIXED ? 1 : 1 - m_last;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_cnt  = 0;
        m_wen  = 1'b0;
    endtask

    task automatic cycle(output int w);
        bit refused;
        #1;
        w = winner();
        chk("ready0", 32'(req0_ready), 32'(w == 0));
        chk("ready1", 32'(req1_ready), 32'(w == 1));
        refused = (req0_valid && w != 0) || (req1_valid && w != 1);
        @(posedge Clk);
        if (refused) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (w >= 0) begin
            m_last  = w;
            m_waddr = 32'((w == 1) ? req1_addr : req0_addr);
            m_wdata = (w == 1) ? req1_data : req0_data;
            m_wen   = (m_waddr != 0);
        end else begin
            m_wen = 1'b0;
        end
        #1;
        chk("wr_en", 32'(wr_en), 32'(m_wen));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        if (m_wen) begin
            chk("wr_addr", 32'(wr_addr), m_waddr);
            chk("wr_data", wr_data, m_wdata);
        end
    endtask

    task automatic do_reset();
        #2 Clrn = 1'b0;
        #1;
        model_reset();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        @(posedge Clk);
        #1 Clrn = 1'b1;
    endtask

    initial begin
        int          w;
        logic [31:0] tie_addr [4];
        logic [31:0] exp_tie  [4];

        Clrn       = 1'b0;
        hold       = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 32'hA;
        req1_valid = 1'b1;
        req1_addr  = 5'd7;
        req1_data  = 32'hB;

        // reset with both requesters pending
        #12;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        Clrn = 1'b1;

        // four-cycle tie
        for (int i = 0; i < 4; i++) begin
            cycle(w);
            tie_addr[i] = 32'(wr_addr);
        end
        if (FIXED) exp_tie = '{32'd7, 32'd7, 32'd7, 32'd7};
        else       exp_tie = '{32'd3, 32'd7, 32'd3, 32'd7};
        for (int i = 0; i < 4; i++) chk("tie_addr", tie_addr[i], exp_tie[i]);
        chk("tie_cnt", 32'(conflict_cnt), 32'd4);

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle(w);

        // zero register write is accepted but does not strobe
        req0_valid = 1'b1;
        req0_addr  = 5'd0;
        req0_data  = 32'h55;
        cycle(w);
        chk("zero_wr_en", 32'(wr_en), 32'd0);
        req0_valid = 1'b0;
        cycle(w);

        // hold for three cycles, then release
        req0_valid = 1'b1;
        req0_addr  = 5'd12;
        req0_data  = 32'h1234;
        req1_valid = 1'b1;
        req1_addr  = 5'd13;
        req1_data  = 32'h5678;
        hold       = 1'b1;
        repeat (3) cycle(w);
        hold = 1'b0;
        cycle(w);
        cycle(w);

        // randomized traffic, requesters stay stable until accepted
        req0_valid = 1'($urandom_range(0, 1));
        req0_addr  = 5'($urandom_range(0, 31));
        req0_data  = $urandom;
        req1_valid = 1'($urandom_range(0, 1));
        req1_addr  = 5'($urandom_range(0, 31));
        req1_data  = $urandom;
        for (int i = 0; i < 150; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            cycle(w);
            if (!req0_valid || w == 0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = 5'($urandom_range(0, 31));
                req0_data  = $urandom;
            end
            if (!req1_valid || w == 1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = 5'($urandom_range(0, 31));
                req1_data  = $urandom;
            end
        end

        // saturation from a clean count
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_reset();
        req1_valid = 1'b1;
        req1_addr  = 5'd4;
        hold       = 1'b1;
        repeat (300) cycle(w);
        chk("sat_cnt", 32'(conflict_cnt), 32'd255);

        // reset lands between a transfer and its write cycle
        hold       = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 5'd9;
        req0_data  = 32'h99;
        cycle(w);
        req0_valid = 1'b0;
        do_reset();
        cycle(w);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);

        // first tie after reset
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req1_valid = 1'b1;
        req1_addr  = 5'd7;
        cycle(w);
        cycle(w);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
